// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined two-level carry-lookahead add/sub with valid/ready; define CLA_OP_COUNT_EN to add op_count
module cla_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             all_prop
`ifdef CLA_OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);
  localparam int NG = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end
  if (GROUP < 2 || GROUP > 8) begin : g_bad_group
    $fatal(1, "cla_adder_pipe: GROUP must be 2..8");
  end
  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $fatal(1, "cla_adder_pipe: PIPE must be 1 or 2");
  end

  // Carry into position n, flattened as a sum of products over bits 0..n-1.
  function automatic logic cy(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                              input logic c0, input int n);
    logic r, t;
    r = c0;
    for (int m = 0; m < n; m++) r &= p[m];
    for (int j = 0; j < n; j++) begin
      t = g[j];
      for (int m = j + 1; m < n; m++) t &= p[m];
      r |= t;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] b_eff, p0, g0;
  logic [NG-1:0]    gp0, gg0;
  logic             cin0;

  always_comb begin
    b_eff = sub ? ~b : b;
    cin0  = sub | carry_in;
    p0    = a ^ b_eff;
    g0    = a & b_eff;
    for (int k = 0; k < NG; k++) begin
      gp0[k] = &p0[k*GROUP +: GROUP];
      gg0[k] = cy(WIDTH'(p0[k*GROUP +: GROUP]), WIDTH'(g0[k*GROUP +: GROUP]), 1'b0, GROUP);
    end
  end

  logic [WIDTH-1:0] x_p, x_g;
  logic [NG-1:0]    x_gp, x_gg;
  logic             x_cin, x_v;

  if (PIPE == 2) begin : g_s1
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gp, s1_gg;
    logic             s1_cin, s1_v;
    always_ff @(posedge clk) begin
      if (rst) s1_v <= 1'b0;
      else if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_p   <= p0;
          s1_g   <= g0;
          s1_gp  <= gp0;
          s1_gg  <= gg0;
          s1_cin <= cin0;
        end
      end
    end
    assign {x_v, x_p, x_g, x_gp, x_gg, x_cin} = {s1_v, s1_p, s1_g, s1_gp, s1_gg, s1_cin};
  end else begin : g_s0
    assign {x_v, x_p, x_g, x_gp, x_gg, x_cin} = {in_valid, p0, g0, gp0, gg0, cin0};
  end

  logic [NG:0]    gc;
  logic [WIDTH:0] c;

  always_comb begin
    for (int k = 0; k <= NG; k++) gc[k] = cy(WIDTH'(x_gp), WIDTH'(x_gg), x_cin, k);
    c        = '0;
    c[WIDTH] = gc[NG];
    for (int k = 0; k < NG; k++)
      for (int i = 0; i < GROUP; i++)
        c[k*GROUP+i] = cy(WIDTH'(x_p[k*GROUP +: GROUP]), WIDTH'(x_g[k*GROUP +: GROUP]), gc[k], i);
  end

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) {out_valid, sum, carry_out, overflow, all_prop} <= '0;
    else if (in_ready) begin
      out_valid <= x_v;
      if (x_v) begin
        sum       <= x_p ^ c[WIDTH-1:0];
        carry_out <= c[WIDTH];
        overflow  <= c[WIDTH] ^ c[WIDTH-1];
        all_prop  <= &x_p;
      end
    end
  end

`ifdef CLA_OP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (out_valid & out_ready) op_count <= op_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed and randomized checks of cla_adder_pipe against an arithmetic reference model
module tb_cla_adder_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       v8, r8i, ov8, or8, cin8, sub8, co8, of8, ap8;
  logic [7:0] a8, b8, s8;
  logic        vr, cinr, subr, orr;
  logic        ir32, ov32, co32, of32, ap32;
  logic [31:0] a32, b32, s32;
  logic        ir16, ov16, co16, of16, ap16;
  logic [15:0] a16, b16, s16;
`ifdef CLA_OP_COUNT_EN
  logic [15:0] cnt8, cnt32, cnt16;
`endif

  cla_adder_pipe #(.WIDTH(8), .GROUP(4), .PIPE(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8i), .a(a8), .b(b8),
    .carry_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .carry_out(co8), .overflow(of8), .all_prop(ap8)
`ifdef CLA_OP_COUNT_EN
    , .op_count(cnt8)
`endif
  );

  cla_adder_pipe #(.WIDTH(32), .GROUP(4), .PIPE(2)) u32 (
    .clk(clk), .rst(rst), .in_valid(vr), .in_ready(ir32), .a(a32), .b(b32),
    .carry_in(cinr), .sub(subr), .out_valid(ov32), .out_ready(orr), .sum(s32),
    .carry_out(co32), .overflow(of32), .all_prop(ap32)
`ifdef CLA_OP_COUNT_EN
    , .op_count(cnt32)
`endif
  );

  cla_adder_pipe #(.WIDTH(16), .GROUP(8), .PIPE(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(vr), .in_ready(ir16), .a(a16), .b(b16),
    .carry_in(cinr), .sub(subr), .out_valid(ov16), .out_ready(orr), .sum(s16),
    .carry_out(co16), .overflow(of16), .all_prop(ap16)
`ifdef CLA_OP_COUNT_EN
    , .op_count(cnt16)
`endif
  );

  // Returns {all_prop, overflow, carry_out, sum} for a w-bit operation.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [63:0] m, be, t;
    logic [31:0] s;
    logic        co, of, ap;
    m  = (64'd1 << w) - 64'd1;
    be = sub ? (~{32'd0, b}) & m : {32'd0, b} & m;
    t  = ({32'd0, a} & m) + be + {63'd0, sub ? 1'b1 : cin};
    s  = t[31:0] & m[31:0];
    co = t[w];
    of = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    ap = (({32'd0, a} ^ be) & m) == m;
    return {ap, of, co, s};
  endfunction

  task automatic test_reset;
    n_cmp++;
    if ({ov8, ap8, of8, co8, s8} !== 12'd0) begin
      n_bad++; $display("FAIL reset_out8 got=%h exp=000", {ov8, ap8, of8, co8, s8});
    end
    n_cmp++;
    if ({r8i, ir32, ir16, ov32, ov16} !== 5'b11100) begin
      n_bad++; $display("FAIL reset_ready got=%b exp=11100", {r8i, ir32, ir16, ov32, ov16});
    end
`ifdef CLA_OP_COUNT_EN
    n_cmp++;
    if (cnt8 !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", cnt8); end
`endif
  endtask

  task automatic test_directed;
    logic [28:0] tbl [5];
    logic [11:0] exp_o;
    tbl = '{{8'hFF, 8'h01, 1'b0, 1'b0, 3'b001, 8'h00},
            {8'h7F, 8'h01, 1'b0, 1'b0, 3'b010, 8'h80},
            {8'h55, 8'hAA, 1'b1, 1'b0, 3'b101, 8'h00},
            {8'h05, 8'h07, 1'b0, 1'b1, 3'b000, 8'hFE},
            {8'h80, 8'h01, 1'b0, 1'b1, 3'b011, 8'h7F}};
    or8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {a8, b8, cin8, sub8} = tbl[i][28:11];
      v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      n_cmp++;
      if (ov8 !== 1'b0) begin n_bad++; $display("FAIL dir_early_valid[%0d] got=%b exp=0", i, ov8); end
      @(posedge clk); #1;
      exp_o = {1'b1, tbl[i][10:0]};
      n_cmp++;
      if ({ov8, ap8, of8, co8, s8} !== exp_o) begin
        n_bad++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, {ov8, ap8, of8, co8, s8}, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [34:0] q[$];
    logic [34:0] e;
    int got = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    or8 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      n_cmp++;
      if (ov8 !== (c >= 2 && c < 12)) begin
        n_bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", c, ov8, (c >= 2 && c < 12));
      end
      if (ov8 && q.size() > 0) begin
        e = q.pop_front();
        got++;
        n_cmp++;
        if ({ap8, of8, co8, s8} !== {e[34:32], e[7:0]}) begin
          n_bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", c, {ap8, of8, co8, s8}, {e[34:32], e[7:0]});
        end
      end
      if (c < 10) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        v8 = 1'b1;
        q.push_back(model({24'd0, a8}, {24'd0, b8}, cin8, sub8, 8));
      end else v8 = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== 10) begin n_bad++; $display("FAIL b2b_count got=%0d exp=10", got); end
`ifdef CLA_OP_COUNT_EN
    n_cmp++;
    if (cnt8 !== 16'd10) begin n_bad++; $display("FAIL b2b_op_count got=%0d exp=10", cnt8); end
`endif
  endtask

  task automatic test_stall;
    logic [34:0] q[$];
    logic [34:0] e;
    logic [10:0] held;
    logic        prev_stall = 1'b0;
    logic        acc;
    int issued = 1;
    int got = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    v8 = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      or8 = !(c >= 5 && c <= 7);
      #1;
      if (ov8 && !or8) begin
        n_cmp++;
        if (r8i !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, r8i); end
        if (prev_stall) begin
          n_cmp++;
          if ({ap8, of8, co8, s8} !== held) begin
            n_bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", c, {ap8, of8, co8, s8}, held);
          end
        end
        held = {ap8, of8, co8, s8};
      end
      prev_stall = ov8 && !or8;
      if (ov8 && or8) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL stall_extra[%0d] got=%h exp=none", c, {ap8, of8, co8, s8});
        end else begin
          e = q.pop_front();
          if ({ap8, of8, co8, s8} !== {e[34:32], e[7:0]}) begin
            n_bad++; $display("FAIL stall_result[%0d] got=%h exp=%h", c, {ap8, of8, co8, s8}, {e[34:32], e[7:0]});
          end
        end
      end
      acc = v8 && r8i;
      if (acc) q.push_back(model({24'd0, a8}, {24'd0, b8}, cin8, sub8, 8));
      @(posedge clk); #1;
      if (acc) begin
        if (issued < 10) begin
          a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
          issued++;
        end else v8 = 1'b0;
      end
    end
    v8 = 1'b0;
    or8 = 1'b1;
    n_cmp++;
    if (got !== 10 || q.size() !== 0) begin
      n_bad++; $display("FAIL stall_count got=%0d left=%0d exp=10 left=0", got, q.size());
    end
`ifdef CLA_OP_COUNT_EN
    n_cmp++;
    if (cnt8 !== 16'd20) begin n_bad++; $display("FAIL stall_op_count got=%0d exp=20", cnt8); end
`endif
  endtask

  task automatic test_reset_midflight;
    or8 = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
    v8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hF0; b8 = 8'h0F;
    @(posedge clk); #1;
    v8 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    or8 = 1'b1;
    n_cmp++;
    if ({ov8, ap8, of8, co8, s8, r8i} !== 13'd1) begin
      n_bad++; $display("FAIL midrst_out got=%h exp=0001", {ov8, ap8, of8, co8, s8, r8i});
    end
`ifdef CLA_OP_COUNT_EN
    n_cmp++;
    if (cnt8 !== 16'd0) begin n_bad++; $display("FAIL midrst_count got=%0d exp=0", cnt8); end
`endif
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (ov8 !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost[%0d] got=%b exp=0", c, ov8); end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int          due;
    logic [34:0] e;
  } ent_t;

  task automatic test_random;
    ent_t q32[$];
    ent_t q16[$];
    ent_t t;
    logic ev;
    orr = 1'b1;
    for (int c = 0; c < 400; c++) begin
      ev = q32.size() > 0 && q32[0].due == c;
      n_cmp++;
      if (ov32 !== ev) begin n_bad++; $display("FAIL rnd32_valid[%0d] got=%b exp=%b", c, ov32, ev); end
      if (ev) begin
        t = q32.pop_front();
        n_cmp++;
        if ({ap32, of32, co32, s32} !== t.e) begin
          n_bad++; $display("FAIL rnd32_result[%0d] got=%h exp=%h", c, {ap32, of32, co32, s32}, t.e);
        end
      end
      ev = q16.size() > 0 && q16[0].due == c;
      n_cmp++;
      if (ov16 !== ev) begin n_bad++; $display("FAIL rnd16_valid[%0d] got=%b exp=%b", c, ov16, ev); end
      if (ev) begin
        t = q16.pop_front();
        n_cmp++;
        if ({ap16, of16, co16, s16} !== {t.e[34:32], t.e[15:0]}) begin
          n_bad++; $display("FAIL rnd16_result[%0d] got=%h exp=%h", c, {ap16, of16, co16, s16}, {t.e[34:32], t.e[15:0]});
        end
      end
      vr   = (c < 380) && ($urandom_range(3) != 0);
      a32  = $urandom; b32 = $urandom;
      a16  = 16'($urandom); b16 = 16'($urandom);
      cinr = 1'($urandom); subr = 1'($urandom);
      if (c % 50 < 5) b32 = a32;
      if (vr) begin
        q32.push_back('{c + 2, model(a32, b32, cinr, subr, 32)});
        q16.push_back('{c + 1, model({16'd0, a16}, {16'd0, b16}, cinr, subr, 16)});
      end
      @(posedge clk); #1;
    end
    vr = 1'b0;
    n_cmp++;
    if (q32.size() != 0 || q16.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain got=%0d/%0d exp=0/0", q32.size(), q16.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
    vr = 1'b0; a32 = '0; b32 = '0; a16 = '0; b16 = '0; cinr = 1'b0; subr = 1'b0; orr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
